// File: rtl/spmv_row_accumulator.sv
// Row accumulator for one SpMV merge-network lane: merges consecutive beats with
// the same row id into a signed sum and emits one (id, sum, count) record per row run.
module spmv_row_accumulator #(
    parameter int IN_WIDTH  = 60,
    parameter int ID_WIDTH  = 13,
    parameter int ACC_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ID_WIDTH-1:0]         in_id,
    input  logic signed [IN_WIDTH-1:0]  in_val,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ID_WIDTH-1:0]         out_id,
    output logic signed [ACC_WIDTH-1:0] out_val,
    output logic [CNT_WIDTH-1:0]        out_cnt,
    output logic                        out_valid,
    input  logic                        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ID_WIDTH-1:0]         r_hold_id;
    logic signed [ACC_WIDTH-1:0] r_hold_acc;
    logic [CNT_WIDTH-1:0]        r_hold_cnt;
    logic [ID_WIDTH-1:0]         w_hold_id_nxt;
    logic signed [ACC_WIDTH-1:0] w_hold_acc_nxt;
    logic [CNT_WIDTH-1:0]        w_hold_cnt_nxt;

    logic [ID_WIDTH-1:0]         r_out_id;
    logic signed [ACC_WIDTH-1:0] r_out_val;
    logic [CNT_WIDTH-1:0]        r_out_cnt;
    logic                        r_out_valid;
    logic [ID_WIDTH-1:0]         w_out_id_nxt;
    logic signed [ACC_WIDTH-1:0] w_out_val_nxt;
    logic [CNT_WIDTH-1:0]        w_out_cnt_nxt;
    logic                        w_out_we;

    logic                        w_slot_free;
    logic                        w_accept;
    logic                        w_same_id;
    logic signed [ACC_WIDTH-1:0] w_beat;
    logic signed [ACC_WIDTH-1:0] w_sum;

    function automatic logic signed [ACC_WIDTH-1:0] sext_val(input logic signed [IN_WIDTH-1:0] v);
        return ACC_WIDTH'(v);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_state != DRAIN) && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    assign w_same_id   = (in_id == r_hold_id);
    assign w_beat      = sext_val(in_val);
    assign w_sum       = r_hold_acc + w_beat;

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_id_nxt  = r_hold_id;
        w_hold_acc_nxt = r_hold_acc;
        w_hold_cnt_nxt = r_hold_cnt;
        w_out_we       = 1'b0;
        w_out_id_nxt   = r_out_id;
        w_out_val_nxt  = r_out_val;
        w_out_cnt_nxt  = r_out_cnt;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_out_we      = 1'b1;
                        w_out_id_nxt  = in_id;
                        w_out_val_nxt = w_beat;
                        w_out_cnt_nxt = CNT_WIDTH'(1);
                    end else begin
                        w_hold_id_nxt  = in_id;
                        w_hold_acc_nxt = w_beat;
                        w_hold_cnt_nxt = CNT_WIDTH'(1);
                        w_state_nxt    = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (w_same_id && !in_last) begin
                        w_hold_acc_nxt = w_sum;
                        w_hold_cnt_nxt = sat_inc(r_hold_cnt);
                    end else if (w_same_id) begin
                        w_out_we       = 1'b1;
                        w_out_id_nxt   = r_hold_id;
                        w_out_val_nxt  = w_sum;
                        w_out_cnt_nxt  = sat_inc(r_hold_cnt);
                        w_hold_id_nxt  = '0;
                        w_hold_acc_nxt = '0;
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = IDLE;
                    end else begin
                        // Id change closes the held run; the new beat starts the next one.
                        w_out_we       = 1'b1;
                        w_out_id_nxt   = r_hold_id;
                        w_out_val_nxt  = r_hold_acc;
                        w_out_cnt_nxt  = r_hold_cnt;
                        w_hold_id_nxt  = in_id;
                        w_hold_acc_nxt = w_beat;
                        w_hold_cnt_nxt = CNT_WIDTH'(1);
                        w_state_nxt    = in_last ? DRAIN : ACCUM;
                    end
                end
            end
            DRAIN: begin
                if (w_slot_free) begin
                    w_out_we       = 1'b1;
                    w_out_id_nxt   = r_hold_id;
                    w_out_val_nxt  = r_hold_acc;
                    w_out_cnt_nxt  = r_hold_cnt;
                    w_hold_id_nxt  = '0;
                    w_hold_acc_nxt = '0;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold_id   <= '0;
            r_hold_acc  <= '0;
            r_hold_cnt  <= '0;
            r_out_id    <= '0;
            r_out_val   <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_id  <= w_hold_id_nxt;
            r_hold_acc <= w_hold_acc_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_out_id   <= w_out_id_nxt;
            r_out_val  <= w_out_val_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            // A fresh record overrides the clear from a same-cycle transfer.
            if (w_out_we) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_id    = r_out_id;
    assign out_val   = r_out_val;
    assign out_cnt   = r_out_cnt;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Directed bench for spmv_row_accumulator: per-cycle vector table plus hand-written
// sequences for wrap-around, count saturation and asynchronous reset.
module tb_spmv_row_accumulator;

    logic               clk;
    logic               rst_n;
    logic [12:0]        in_id;
    logic signed [59:0] in_val;
    logic               in_last;
    logic               in_valid;
    logic               out_ready;

    logic               in_ready;
    logic [12:0]        out_id;
    logic signed [63:0] out_val;
    logic [15:0]        out_cnt;
    logic               out_valid;

    logic               wr_in_ready;
    logic [12:0]        wr_out_id;
    logic signed [59:0] wr_out_val;
    logic [1:0]         wr_out_cnt;
    logic               wr_out_valid;

    int checks = 0;
    int errors = 0;

    spmv_row_accumulator #(
        .IN_WIDTH(60), .ID_WIDTH(13), .ACC_WIDTH(64), .CNT_WIDTH(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_id(in_id), .in_val(in_val), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready),
        .out_id(out_id), .out_val(out_val), .out_cnt(out_cnt), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Narrow variant: accumulator as wide as the input, 2-bit counter.
    spmv_row_accumulator #(
        .IN_WIDTH(60), .ID_WIDTH(13), .ACC_WIDTH(60), .CNT_WIDTH(2)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_id(in_id), .in_val(in_val), .in_last(in_last), .in_valid(in_valid),
        .in_ready(wr_in_ready),
        .out_id(wr_out_id), .out_val(wr_out_val), .out_cnt(wr_out_cnt), .out_valid(wr_out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               v;
        logic [12:0]        id;
        logic signed [59:0] val;
        logic               last;
        logic               ordy;
        logic               e_rdy;
        logic               e_ov;
        logic [12:0]        e_id;
        logic [63:0]        e_val;
        logic [15:0]        e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [12:0] id, input logic signed [59:0] val,
                         input logic last, input logic ordy);
        in_valid  = v;
        in_id     = id;
        in_val    = val;
        in_last   = last;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic signed [59:0] MAXP = 60'sh7FF_FFFF_FFFF_FFFF;

    initial begin
        tbl.push_back('{1'b1, 13'd5,  60'sd3,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd5,  60'sd4,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd5,  -60'sd2,  1'b1, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b1, 13'd5, 64'd5, 16'd3});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd1,  60'sd10,  1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd2,  60'sd20,  1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd2,  60'sd1,   1'b1, 1'b1, 1'b1, 1'b1, 13'd1, 64'd10, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b1, 13'd2, 64'd21, 16'd2});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd7,  60'sd4,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd9,  60'sd6,   1'b1, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd11, 60'sd100, 1'b1, 1'b1, 1'b0, 1'b1, 13'd7, 64'd4, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b1, 13'd9, 64'd6, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd3,  -60'sd1,  1'b1, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b1, 13'd3, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd4,  60'sd8,   1'b1, 1'b0, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1'b1, 13'd6, 60'sd1, 1'b1, 1'b0, 1'b0, 1'b1, 13'd4, 64'd8, 16'd1});
        tbl.push_back('{1'b1, 13'd6,  60'sd1,   1'b1, 1'b1, 1'b1, 1'b1, 13'd4, 64'd8, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b1, 13'd6, 64'd1, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd1,  60'sd2,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd2,  60'sd3,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 13'd1,  60'sd4,   1'b1, 1'b1, 1'b1, 1'b1, 13'd1, 64'd2, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b0, 1'b1, 13'd2, 64'd3, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b1, 13'd1, 64'd4, 16'd1});
        tbl.push_back('{1'b0, 13'd0,  60'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 13'd0, 64'd0, 16'd0});

        rst_n = 1'b0;
        drive(1'b0, 13'd0, 60'sd0, 1'b0, 1'b1);
        #12;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_id", 64'(out_id), 64'd0);
        chk("reset out_val", out_val, 64'd0);
        chk("reset out_cnt", 64'(out_cnt), 64'd0);
        chk("reset wrap out_valid", 64'(wr_out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].id, tbl[i].val, tbl[i].last, tbl[i].ordy);
            #1;
            chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("row%0d out_id", i), 64'(out_id), 64'(tbl[i].e_id));
                chk($sformatf("row%0d out_val", i), out_val, tbl[i].e_val);
                chk($sformatf("row%0d out_cnt", i), 64'(out_cnt), 64'(tbl[i].e_cnt));
            end
            step();
        end

        // Two max-positive beats: wraps to -2 in the narrow accumulator only.
        drive(1'b1, 13'd2, MAXP, 1'b0, 1'b1); step();
        drive(1'b1, 13'd2, MAXP, 1'b1, 1'b1); step();
        drive(1'b0, 13'd0, 60'sd0, 1'b0, 1'b1); #1;
        chk("wide sum out_valid", 64'(out_valid), 64'd1);
        chk("wide sum out_val", out_val, 64'h0FFF_FFFF_FFFF_FFFE);
        chk("wide sum out_cnt", 64'(out_cnt), 64'd2);
        chk("wrap out_valid", 64'(wr_out_valid), 64'd1);
        chk("wrap out_val", {{4{wr_out_val[59]}}, wr_out_val}, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap out_cnt", 64'(wr_out_cnt), 64'd2);
        step();

        // Six merged beats: narrow counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 13'd3, 60'sd1, 1'b0, 1'b1); step();
        end
        drive(1'b1, 13'd3, 60'sd1, 1'b1, 1'b1); step();
        drive(1'b0, 13'd0, 60'sd0, 1'b0, 1'b1); #1;
        chk("sat out_val", out_val, 64'd6);
        chk("sat out_cnt", 64'(out_cnt), 64'd6);
        chk("sat wrap out_cnt", 64'(wr_out_cnt), 64'd3);
        chk("sat wrap out_val", 64'(wr_out_val), 64'd6);
        step();

        // Reset with a pending record and a live partial sum.
        drive(1'b1, 13'd8, 60'sd5, 1'b0, 1'b0); step();
        drive(1'b1, 13'd9, 60'sd5, 1'b0, 1'b0); step();
        drive(1'b0, 13'd0, 60'sd0, 1'b0, 1'b0); #1;
        chk("prereset out_valid", 64'(out_valid), 64'd1);
        chk("prereset out_id", 64'(out_id), 64'd8);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst out_val", out_val, 64'd0);
        chk("async rst out_id", 64'(out_id), 64'd0);
        chk("async rst wrap out_valid", 64'(wr_out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post rst idle%0d out_valid", k), 64'(out_valid), 64'd0);
            chk($sformatf("post rst idle%0d in_ready", k), 64'(in_ready), 64'd1);
            step();
        end
        drive(1'b1, 13'd9, 60'sd1, 1'b1, 1'b1); step();
        drive(1'b0, 13'd0, 60'sd0, 1'b0, 1'b1); #1;
        chk("post rst out_valid", 64'(out_valid), 64'd1);
        chk("post rst out_id", 64'(out_id), 64'd9);
        chk("post rst out_val", out_val, 64'd1);
        chk("post rst out_cnt", 64'(out_cnt), 64'd1);
        chk("post rst wrap in_ready", 64'(wr_in_ready), 64'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
